muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the execute stage. It sits beside the ALU and takes the same rs/rt operands that feed it. It executes MULT, MULTU, DIV and DIVU over N+2 cycles, holds results in the architectural HI/LO registers, and serves MFHI/MFLO reads and MTHI/MTLO writes. Control logic stalls the pipeline on `busy`.

## Interface
Parameters:
- `N`, default 32: operand and HI/LO width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: launch the operation given by `op_code`; sampled only in IDLE.
- `op_code`, in, 2: `MD_OP_MULT`=0, `MD_OP_MULTU`=1, `MD_OP_DIV`=2, `MD_OP_DIVU`=3.
- `x`, in, N: rs operand (multiplicand or dividend).
- `y`, in, N: rt operand (multiplier or divisor).
- `hi_we`, in, 1: MTHI write enable.
- `lo_we`, in, 1: MTLO write enable.
- `wdata`, in, N: MTHI/MTLO data.
- `busy`, out, 1: an operation is in flight.
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`, out, 1: one-cycle pulse together with `done` for DIV/DIVU with `y`=0.
- `hi`, out, N: HI register.
- `lo`, out, N: LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE to RUN on `start`.
  - RUN to FIX when the iteration counter reaches 0.
  - FIX to IDLE unconditionally.
- Launch (IDLE with `start`):
  - Latch `op_code`.
  - For signed ops, latch |x| and |y| and record the sign flags. For unsigned ops, latch x and y as given.
  - Load counter = N-1.
- RUN: one radix-2 step per cycle; the counter decrements each cycle.
  - Multiply: shift-add into a 2N-bit product.
  - Divide: restoring shift-subtract, producing an N-bit quotient and an N-bit remainder.
- FIX:
  - Apply sign correction. The product is negated if the sign flags differ. The quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - Write HI/LO: multiply gives HI = product[2N-1:N] and LO = product[N-1:0]; divide gives LO = quotient and HI = remainder.
- Divide by zero: the result comes out of the normal datapath and takes the same latency.
  - LO = all ones; HI = x (the original, unsigned-view value). The signed divide-by-zero quotient is not sign-corrected: LO stays all ones.
  - `div_by_zero` pulses with `done`.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This requires no special case.
- `start` while not IDLE is ignored, with no queueing.
- `hi_we`/`lo_we` while `busy` are ignored.
  - In IDLE they write on the next edge.
  - If they arrive together with `start`, the write is applied and the operation still launches; FIX later overwrites HI/LO.
- `hi` and `lo` are direct register outputs. They hold their previous value until FIX completes.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter=0.
- Reset asserted mid-operation aborts it: next cycle IDLE, outputs at reset values, and no `done` pulse.
- Operation timeline, with `start` sampled at edge E0:
  - `busy`=1 after E0 and stays high through the cycle after edge E(N+1).
  - HI/LO update at edge E(N+2).
  - `done` is high for exactly the one cycle following edge E(N+2), and `busy`=0 in that cycle.
  - Total latency: N+2 edges (34 for N=32).
- Back-to-back: a new `start` is accepted in the cycle where `done`=1.
- Operand inputs need only be valid in the `start` cycle.
- `busy` is combinational from state (state != IDLE). `done` and `div_by_zero` are registered.

## Structure
- Shared define file `muldiv_defines.v` sits alongside the ALU defines and holds:
  - the `MD_OP_MULT`, `MD_OP_MULTU`, `MD_OP_DIV`, `MD_OP_DIVU` codes;
  - the FSM state encodings `MD_ST_IDLE`, `MD_ST_RUN`, `MD_ST_FIX`.
- Single module, no sub-modules. The step logic is small enough to sit inline: one shared 2N-bit shift register plus an (N+1)-bit adder/subtractor.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 34 edges after `start`; `busy` high for 33 cycles.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, `div_by_zero`=1 with `done`. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` pulsed again at cycle 10 of a running op with different operands → ignored; the first result is unchanged. `hi_we` mid-op → HI unchanged. MTLO 0x1234 in IDLE → `lo`=0x1234 next cycle.
- `rst` at cycle 15 of a DIVU → `busy`=0, `hi`=`lo`=0, no `done`. A fresh MULTU 7 × 6 immediately after → LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM encodings and decode helpers for the iterative
// multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'd0,
    MD_OP_MULTU = 2'd1,
    MD_OP_DIV   = 2'd2,
    MD_OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_RUN  = 2'd1,
    MD_ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with architectural HI/LO registers.
// One shared 2N-bit shift register; sign handling at launch and in FIX.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op_code,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  md_state_e      state, state_nxt;
  md_op_e         op_q;
  logic [N-1:0]   a_q, b_q;
  logic           sx_q, sy_q, dz_q, primed_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q;

  // launch-side operand conditioning
  md_op_e         op_in;
  logic           x_neg, y_neg;
  logic [N-1:0]   x_abs, y_abs;

  // per-step datapath
  logic           is_div;
  logic [N:0]     rsh;
  logic [N+1:0]   diff;
  logic [N:0]     psum;
  logic [2*N-1:0] acc_step;

  // sign correction
  logic           neg;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quot, rem, quot_f, rem_f;
  logic [N-1:0]   hi_res, lo_res;

  assign busy = (state != MD_ST_IDLE);

  always_comb begin
    op_in = md_op_e'(op_code);
    x_neg = op_is_signed(op_in) & x[N-1];
    y_neg = op_is_signed(op_in) & y[N-1];
    x_abs = x_neg ? (~x + 1'b1) : x;
    y_abs = y_neg ? (~y + 1'b1) : y;
  end

  // Multiply consumes the multiplier from acc LSB and accumulates into the
  // upper half; divide shifts the dividend out of the lower half into the
  // partial remainder while quotient bits enter at the bottom.
  always_comb begin
    is_div = op_is_div(op_q);
    rsh    = {acc_q[2*N-1:N], acc_q[N-1]};
    diff   = {1'b0, rsh} - {2'b00, b_q};
    psum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? a_q : {N{1'b0}})};
    if (is_div) begin
      if (diff[N+1]) acc_step = {rsh[N-1:0],  acc_q[N-2:0], 1'b0};
      else           acc_step = {diff[N-1:0], acc_q[N-2:0], 1'b1};
    end else begin
      acc_step = {psum, acc_q[N-1:1]};
    end
  end

  // A zero divisor leaves the quotient all ones and the remainder equal to
  // |x|; only the quotient must skip the sign fix so LO stays all ones.
  always_comb begin
    neg    = sx_q ^ sy_q;
    prod   = neg ? (~acc_q + 1'b1) : acc_q;
    quot   = acc_q[N-1:0];
    rem    = acc_q[2*N-1:N];
    quot_f = (neg && !dz_q) ? (~quot + 1'b1) : quot;
    rem_f  = sx_q ? (~rem + 1'b1) : rem;
    if (is_div) begin
      hi_res = rem_f;
      lo_res = quot_f;
    end else begin
      hi_res = prod[2*N-1:N];
      lo_res = prod[N-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_ST_IDLE: if (start) state_nxt = MD_ST_RUN;
      MD_ST_RUN:  if (primed_q && cnt_q == '0) state_nxt = MD_ST_FIX;
      MD_ST_FIX:  state_nxt = MD_ST_IDLE;
      default:    state_nxt = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MD_ST_IDLE;
      op_q        <= MD_OP_MULT;
      a_q         <= '0;
      b_q         <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      dz_q        <= 1'b0;
      primed_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_nxt;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        MD_ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q     <= op_in;
            a_q      <= x_abs;
            b_q      <= y_abs;
            sx_q     <= x_neg;
            sy_q     <= y_neg;
            dz_q     <= (y == '0);
            cnt_q    <= CW'(N - 1);
            primed_q <= 1'b0;
          end
        end
        MD_ST_RUN: begin
          // First RUN cycle seeds the shift register from the latched
          // operands, keeping the abs negators off the acc input path.
          if (!primed_q) begin
            acc_q    <= {{N{1'b0}}, (is_div ? a_q : b_q)};
            primed_q <= 1'b1;
          end else begin
            acc_q <= acc_step;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          end
        end
        MD_ST_FIX: begin
          hi          <= hi_res;
          lo          <= lo_res;
          done        <= 1'b1;
          div_by_zero <= is_div & dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO computed from 64-bit
// integer arithmetic at launch, compared when done pulses.
module tb_muldiv_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] x = '0, y = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  muldiv_unit #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .x(x), .y(y), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_, q, r;
    e = '0;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      2'd0: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sb_; r = sa % sb_;
          p = 64'(q); e.lo = p[31:0];
          p = 64'(r); e.hi = p[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Drives a one-cycle start (caller positions us away from the edge) and
  // scrambles the operands afterwards; returns #1 after the launch edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(o, a, b));
    op_code = o; x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; op_code = 2'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bcnt, output logic ok);
    cyc = 0; bcnt = 0; ok = 1'b0;
    while (cyc < 200 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (done) ok = 1'b1;
      else if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu_timing;
    int cyc, bcnt; logic ok; exp_t e;
    @(negedge clk);
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_e0 got=%b want=1", busy); end
    wait_done(cyc, bcnt, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL multu_timeout got=no_done want=done"); end
    checks++; if (cyc != 34) begin errors++; $display("FAIL multu_latency got=%0d want=34", cyc); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL multu_busy_cycles_after_e1 got=%0d want=33", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL multu_hi got=%h want=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL multu_lo got=%h want=%h", lo, e.lo); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi_const got=%h want=fffffffe", hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL multu_dbz got=%b want=0", div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width got=%b want=0", done); end
  endtask

  // Signed/unsigned cases and boundaries, each launched in the previous
  // op's done cycle.
  task automatic test_back_to_back;
    logic [1:0]  ops[14];
    logic [31:0] xs[14], ys[14];
    int cyc, bcnt; logic ok; exp_t e;
    ops[0] = 2'd0; xs[0] = 32'hFFFF_FFFD; ys[0] = 32'd5;
    ops[1] = 2'd2; xs[1] = 32'hFFFF_FFF9; ys[1] = 32'd2;
    ops[2] = 2'd3; xs[2] = 32'd100;       ys[2] = 32'd0;
    ops[3] = 2'd2; xs[3] = 32'h8000_0000; ys[3] = 32'hFFFF_FFFF;
    ops[4] = 2'd2; xs[4] = 32'hFFFF_FF9C; ys[4] = 32'd0;
    ops[5] = 2'd0; xs[5] = 32'h8000_0000; ys[5] = 32'h8000_0000;
    ops[6] = 2'd3; xs[6] = 32'hFFFF_FFFF; ys[6] = 32'd7;
    ops[7] = 2'd1; xs[7] = 32'hFFFF_FFFF; ys[7] = 32'd0;
    for (int i = 8; i < 14; i++) begin
      ops[i] = 2'(i); xs[i] = $urandom; ys[i] = $urandom_range(1, 32'hFFFF);
    end
    @(negedge clk);
    launch(ops[0], xs[0], ys[0]);
    for (int i = 0; i < 14; i++) begin
      wait_done(cyc, bcnt, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_timeout op#%0d got=no_done want=done", i);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      if (i + 1 < 14) begin
        op_code = ops[i+1]; x = xs[i+1]; y = ys[i+1]; start = 1'b1;
        sb.push_back(model(ops[i+1], xs[i+1], ys[i+1]));
      end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL b2b_hi op#%0d got=%h want=%h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b_lo op#%0d got=%h want=%h", i, lo, e.lo); end
      checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL b2b_dbz op#%0d got=%b want=%b", i, div_by_zero, e.dbz); end
      checks++; if (cyc != 34) begin errors++; $display("FAIL b2b_latency op#%0d got=%0d want=34", i, cyc); end
      if (i + 1 < 14) begin
        @(posedge clk); #1;
        start = 1'b0; x = $urandom; y = $urandom;
      end
    end
  endtask

  task automatic test_ignore_start_and_mthi;
    int cyc, bcnt; logic ok, seen; exp_t e;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk); hi_we = 1'b0;
    launch(2'd1, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op_code = 2'd2; x = 32'd99; y = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_5555) begin errors++; $display("FAIL mthi_busy got=%h want=00005555", hi); end
    wait_done(cyc, bcnt, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got=no_done want=done"); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL ignore_lo got=%h want=%h", lo, e.lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL ignore_hi got=%h want=%h", hi, e.hi); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ignore_second_op got=activity want=idle"); end
  endtask

  task automatic test_mtlo_mthi;
    int cyc, bcnt; logic ok; exp_t e;
    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++; if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo got=%h want=00001234", lo); end
    @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_ABCD;
    launch(2'd1, 32'd3, 32'd4);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL mthi_with_start got=%h want=0000abcd", hi); end
    wait_done(cyc, bcnt, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL mthi_start_timeout got=no_done want=done"); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL mthi_start_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_mid_op;
    int cyc, bcnt; logic ok, seen; exp_t e;
    @(negedge clk);
    launch(2'd3, 32'd1000, 32'd7);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    void'(sb.pop_back());
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo got=%h_%h want=0_0", hi, lo); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=pulse want=none"); end
    @(negedge clk);
    launch(2'd1, 32'd7, 32'd6);
    wait_done(cyc, bcnt, ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_timeout got=no_done want=done"); end
    checks++; if (lo !== e.lo || lo !== 32'd42) begin errors++; $display("FAIL post_rst_lo got=%h want=0000002a", lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL post_rst_hi got=%h want=%h", hi, e.hi); end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_back_to_back();
    test_ignore_start_and_mthi();
    test_mtlo_mthi();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
